// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control decoder.
// The ALU_CTRL_ILLEGAL_EN build option is handled in the decoder files; nothing here depends on it.
package alu_ctrl_pkg;

    localparam int ALUC_BITS = 5;

    typedef enum logic [2:0] {
        ALUOP_RTYPE  = 3'b000,
        ALUOP_ITYPE  = 3'b001,
        ALUOP_BRANCH = 3'b010,
        ALUOP_JUMP   = 3'b011,
        ALUOP_LDST   = 3'b100,
        ALUOP_LUI    = 3'b101,
        ALUOP_AUIPC  = 3'b110,
        ALUOP_RSVD   = 3'b111
    } aluop_e;

    localparam logic [ALUC_BITS-1:0] ALUC_ADD      = 5'b00000;
    localparam logic [ALUC_BITS-1:0] ALUC_PASS_B   = 5'b10010;
    localparam logic [ALUC_BITS-1:0] ALUC_PASS_PC4 = 5'b11111;

    localparam logic [1:0] ALUC_BRANCH_PFX = 2'b10;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_RSV_BR0 = 3'b010;
    localparam logic [2:0] F3_RSV_BR1 = 3'b011;

    // Arithmetic codes follow the ALU's {funct7b5, funct3} map.
    function automatic logic [ALUC_BITS-1:0] arith_code(input logic f7b5, input logic [2:0] f3);
        return {1'b0, f7b5, f3};
    endfunction

    function automatic logic [ALUC_BITS-1:0] branch_code(input logic [2:0] f3);
        return {ALUC_BRANCH_PFX, f3};
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational aluop/funct -> ALU operation code table.
// With ALU_CTRL_ILLEGAL_EN defined, also flags illegal aluop/funct combinations.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0]           aluop_i,
    input  logic [2:0]           func3_i,
    input  logic                 func7_i,
`ifdef ALU_CTRL_ILLEGAL_EN
    output logic                 illegal_o,
`endif
    output logic [ALUC_BITS-1:0] aluc_o
);

    // Unused funct fields are never touched, so X on them cannot reach aluc_o.
    always_comb begin
        aluc_o = ALUC_ADD;
        case (aluop_e'(aluop_i))
            ALUOP_RTYPE: aluc_o = arith_code(func7_i, func3_i);
            ALUOP_ITYPE: begin
                if (func3_i == F3_SRL_SRA) begin
                    aluc_o = arith_code(func7_i, func3_i);
                end else begin
                    aluc_o = arith_code(1'b0, func3_i);
                end
            end
            ALUOP_BRANCH: aluc_o = branch_code(func3_i);
            ALUOP_JUMP:   aluc_o = ALUC_PASS_PC4;
            ALUOP_LDST:   aluc_o = ALUC_ADD;
            ALUOP_LUI:    aluc_o = ALUC_PASS_B;
            ALUOP_AUIPC:  aluc_o = ALUC_ADD;
            ALUOP_RSVD:   aluc_o = ALUC_ADD;
            default:      aluc_o = ALUC_ADD;
        endcase
    end

`ifdef ALU_CTRL_ILLEGAL_EN
    // Reserved class, funct7b5 on R-type ops other than ADD/SUB or SRL/SRA, and undefined branch funct3 codes.
    always_comb begin
        illegal_o = 1'b0;
        case (aluop_e'(aluop_i))
            ALUOP_RTYPE: begin
                if (func7_i && (func3_i != F3_ADD_SUB) && (func3_i != F3_SRL_SRA)) begin
                    illegal_o = 1'b1;
                end else begin
                    illegal_o = 1'b0;
                end
            end
            ALUOP_BRANCH: begin
                if ((func3_i == F3_RSV_BR0) || (func3_i == F3_RSV_BR1)) begin
                    illegal_o = 1'b1;
                end else begin
                    illegal_o = 1'b0;
                end
            end
            ALUOP_RSVD: illegal_o = 1'b1;
            default:    illegal_o = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_ctrl_decoder.sv
// ALU control decoder: combinational decode table followed by one output register.
// Defining ALU_CTRL_ILLEGAL_EN adds the registered illegal_o flag.
module alu_ctrl_decoder
    import alu_ctrl_pkg::*;
#(
    parameter int ALUC_W = ALUC_BITS
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [2:0]        aluop_i,
    input  logic [2:0]        func3_i,
    input  logic              func7_i,
`ifdef ALU_CTRL_ILLEGAL_EN
    output logic              illegal_o,
`endif
    output logic [ALUC_W-1:0] aluc_o
);

    logic [ALUC_W-1:0] w_aluc;
    logic [ALUC_W-1:0] r_aluc;

`ifdef ALU_CTRL_ILLEGAL_EN
    logic w_illegal;
    logic r_illegal;
`endif

    alu_ctrl_decode u_decode (
        .aluop_i   (aluop_i),
        .func3_i   (func3_i),
        .func7_i   (func7_i),
`ifdef ALU_CTRL_ILLEGAL_EN
        .illegal_o (w_illegal),
`endif
        .aluc_o    (w_aluc)
    );

    // Output register; reset value is the ADD code.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aluc <= ALUC_ADD;
        end else begin
            r_aluc <= w_aluc;
        end
    end

    assign aluc_o = r_aluc;

`ifdef ALU_CTRL_ILLEGAL_EN
    // Illegal flag register, aligned with aluc_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_illegal;
        end
    end

    assign illegal_o = r_illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Self-checking bench for alu_ctrl_decoder: directed steps plus randomized decode
// checked against a table-level reference model.
module tb_alu_ctrl_decoder;

    logic       clk_i;
    logic       rst_ni;
    logic [2:0] aluop_i;
    logic [2:0] func3_i;
    logic       func7_i;
    logic [4:0] aluc_o;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic       illegal_o;
`endif

    int n_tests;
    int n_fail;

    alu_ctrl_decoder dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .aluop_i   (aluop_i),
        .func3_i   (func3_i),
        .func7_i   (func7_i),
`ifdef ALU_CTRL_ILLEGAL_EN
        .illegal_o (illegal_o),
`endif
        .aluc_o    (aluc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [4:0] ref_aluc(input logic [2:0] op, input logic [2:0] f3, input logic f7);
        int v;
        v = 0;
        if (op == 3'd0) v = (f7 ? 8 : 0) + int'(f3);
        else if (op == 3'd1) v = ((f3 == 3'd5 && f7) ? 8 : 0) + int'(f3);
        else if (op == 3'd2) v = 16 + int'(f3);
        else if (op == 3'd3) v = 31;
        else if (op == 3'd5) v = 18;
        else v = 0;
        return v[4:0];
    endfunction

    function automatic logic ref_illegal(input logic [2:0] op, input logic [2:0] f3, input logic f7);
        if (op == 3'd7) return 1'b1;
        if (op == 3'd0 && f7 && !(f3 == 3'd0 || f3 == 3'd5)) return 1'b1;
        if (op == 3'd2 && (f3 == 3'd2 || f3 == 3'd3)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_aluc(input string tag, input logic [4:0] exp);
        n_tests++;
        assert (aluc_o === exp) else begin
            n_fail++;
            $error("FAIL %s: aluc_o=%b expected %b", tag, aluc_o, exp);
        end
    endtask

    task automatic check_ill(input string tag, input logic exp);
`ifdef ALU_CTRL_ILLEGAL_EN
        n_tests++;
        assert (illegal_o === exp) else begin
            n_fail++;
            $error("FAIL %s: illegal_o=%b expected %b", tag, illegal_o, exp);
        end
`else
        if (tag.len() < 0 || exp === 1'bz) $display("unused");
`endif
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic [2:0] op, input logic [2:0] f3, input logic f7);
        @(negedge clk_i);
        aluop_i = op;
        func3_i = f3;
        func7_i = f7;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [2:0] op;
        logic [2:0] f3;
        logic       f7;
        n_tests = 0;
        n_fail  = 0;

        rst_ni  = 1'b0;
        aluop_i = 3'b011;
        func3_i = 3'b000;
        func7_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_aluc("reset_hold", 5'b00000);
        check_ill("reset_hold_ill", 1'b0);

        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_aluc("first_after_reset", 5'b11111);

        step(3'b000, 3'b010, 1'b0);  check_aluc("rtype_slt", 5'b00010);
        step(3'b000, 3'b000, 1'b1);  check_aluc("rtype_sub", 5'b01000);
        step(3'b001, 3'b001, 1'bx);  check_aluc("itype_slli_x", 5'b00001);
        step(3'b001, 3'b101, 1'b1);  check_aluc("itype_srai", 5'b01101);
        step(3'b001, 3'b000, 1'b1);  check_aluc("itype_addi_f7", 5'b00000);
        step(3'b011, 3'bxxx, 1'bx);  check_aluc("jump_x", 5'b11111);
        step(3'b101, 3'bxxx, 1'bx);  check_aluc("lui_x", 5'b10010);
        step(3'b110, 3'bxxx, 1'bx);  check_aluc("auipc_x", 5'b00000);
        step(3'b100, 3'bxxx, 1'bx);  check_aluc("ldst_x", 5'b00000);
        step(3'b111, 3'b110, 1'b1);  check_aluc("rsvd", 5'b00000);
        check_ill("rsvd_ill", 1'b1);
        step(3'b000, 3'b001, 1'b1);  check_ill("rtype_f7_sll_ill", 1'b1);
        step(3'b000, 3'b101, 1'b1);  check_ill("rtype_sra_ok", 1'b0);
        step(3'b010, 3'b011, 1'b0);  check_ill("branch_011_ill", 1'b1);
        step(3'b010, 3'b101, 1'bx);  check_aluc("branch_bge_x", 5'b10101);
        check_ill("branch_bge_ok", 1'b0);

        // Async reset between edges must clear outputs without a clock edge.
        #2;
        rst_ni = 1'b0;
        #1;
        check_aluc("async_reset", 5'b00000);
        check_ill("async_reset_ill", 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            step(op, f3, f7);
            check_aluc("random", ref_aluc(op, f3, f7));
            check_ill("random_ill", ref_illegal(op, f3, f7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
